// File: rtl/exe_hazard_unit.sv
// -----------------------------------------------------------------------------
// exe_hazard_unit
//
// Purpose:
//   Hazard and stall controller on the consuming side of the ID/EXE pipeline
//   register. It looks at the registered ID/EXE control fields, the source
//   register indices currently in IF/ID, and the branch outcome resolved in
//   EXE. From these it drives the PC / IF/ID / ID/EXE load-enable, hold,
//   bubble and flush controls. Three hazards are resolved:
//     * load-use        : one stall cycle plus a bubble into ID/EXE
//     * taken branch    : IF/ID flushed, ID/EXE bubbled, no stall
//     * FP mul/div      : EXE occupied for N cycles, front end held N-1 cycles
//   Two saturating performance counters track stall cycles and flush cycles.
//
// Ports:
//   clk, rst_n          : single clock, asynchronous active-low reset
//   ID_EXE_MemRead      : instruction in EXE is a load
//   ID_EXE_RtReg [4:0]  : load destination register index
//   ID_EXE_fmt   [4:0]  : FP format (5'h10 single, 5'h11 double, else not FP)
//   ID_EXE_Func  [5:0]  : function code (6'h02 mul, 6'h03 div)
//   ID_EXE_double       : double precision; selects the div.d latency
//   IF_ID_Rs/Rt  [4:0]  : source indices of the instruction in ID
//   BranchTaken         : branch in EXE resolved taken this cycle
//   PCWrite             : PC load enable
//   IF_ID_Write         : IF/ID load enable
//   IF_ID_Flush         : IF/ID clears to NOP at the next edge
//   ID_EXE_Bubble       : ID/EXE loads all-zero control at the next edge
//   ID_EXE_Hold         : ID/EXE keeps its contents at the next edge
//   Busy                : a multi-cycle FP op occupies EXE
//   StallCount [31:0]   : saturating count of edges with PCWrite=0
//   FlushCount [31:0]   : saturating count of edges with IF_ID_Flush=1
//
// Handshake / control semantics:
//   All controls are combinational from the current state and inputs, valid
//   for the edge that closes the current cycle. Hold and Bubble are mutually
//   exclusive, Flush always comes with Bubble, and IF_ID_Write follows PCWrite.
//   The FSM state is visible externally through Busy (BUSY state, or the RUN
//   cycle that launches a multi-cycle op).
// -----------------------------------------------------------------------------
module exe_hazard_unit #(
    // All latencies must be at least 2 and at most 17 (4-bit countdown).
    parameter int MUL_CYCLES   = 3,
    parameter int DIV_S_CYCLES = 6,
    parameter int DIV_D_CYCLES = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ID_EXE_MemRead,
    input  logic [4:0]  ID_EXE_RtReg,
    input  logic [4:0]  ID_EXE_fmt,
    input  logic [5:0]  ID_EXE_Func,
    input  logic        ID_EXE_double,
    input  logic [4:0]  IF_ID_Rs,
    input  logic [4:0]  IF_ID_Rt,
    input  logic        BranchTaken,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EXE_Bubble,
    output logic        ID_EXE_Hold,
    output logic        Busy,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    // The launching RUN cycle is the first of N occupancy cycles and the
    // BUSY cycle with cnt==0 is the last, so BUSY is entered with N-2.
    localparam logic [3:0]  MUL_LOAD   = 4'(MUL_CYCLES - 2);
    localparam logic [3:0]  DIV_S_LOAD = 4'(DIV_S_CYCLES - 2);
    localparam logic [3:0]  DIV_D_LOAD = 4'(DIV_D_CYCLES - 2);
    localparam logic [31:0] CNT_MAX    = 32'hFFFF_FFFF;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Hazard detection terms
    logic       is_fp;
    logic       is_mul;
    logic       is_div;
    logic       mc;
    logic       lu;
    logic [3:0] n_load;

    // Internal control values
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_exe_bubble;
    logic id_exe_hold;
    logic busy;

    always_comb begin
        is_fp  = (ID_EXE_fmt == 5'h10) || (ID_EXE_fmt == 5'h11);
        is_mul = (ID_EXE_Func == 6'h02);
        is_div = (ID_EXE_Func == 6'h03);
        mc     = is_fp && (is_mul || is_div);

        if (is_div) begin
            n_load = ID_EXE_double ? DIV_D_LOAD : DIV_S_LOAD;
        end else begin
            n_load = MUL_LOAD;
        end

        // Register 0 is hardwired, so a load targeting it never creates a hazard.
        lu = ID_EXE_MemRead && (ID_EXE_RtReg != 5'd0) &&
             ((ID_EXE_RtReg == IF_ID_Rs) || (ID_EXE_RtReg == IF_ID_Rt));
    end

    // Next-state and control outputs
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_exe_bubble = 1'b0;
        id_exe_hold   = 1'b0;
        busy          = 1'b0;

        case (state_q)
            S_RUN: begin
                if (BranchTaken) begin
                    // Wrong-path instructions in IF/ID and ID are squashed;
                    // the front end keeps fetching from the branch target.
                    if_id_flush   = 1'b1;
                    id_exe_bubble = 1'b1;
                end else if (mc) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_exe_hold = 1'b1;
                    busy        = 1'b1;
                    cnt_d       = n_load;
                    state_d     = S_BUSY;
                end else if (lu) begin
                    // The bubble zeroes MemRead in ID/EXE, so next cycle lu
                    // drops on its own and no state is needed.
                    pc_write      = 1'b0;
                    if_id_write   = 1'b0;
                    id_exe_bubble = 1'b1;
                end
            end

            S_BUSY: begin
                // Branch and load-use inputs describe a stale or held
                // instruction while EXE is occupied, so they are ignored.
                busy = 1'b1;
                if (cnt_q != 4'd0) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_exe_hold = 1'b1;
                    cnt_d       = cnt_q - 4'd1;
                end else begin
                    // Last occupancy cycle: the op retires from EXE at this
                    // edge and the pipeline advances.
                    state_d = S_RUN;
                end
            end

            default: begin
                state_d = S_RUN;
                cnt_d   = 4'd0;
            end
        endcase

        // While reset is asserted the state is RUN regardless of inputs, and
        // the controls must read as idle even if a multi-cycle op is still
        // sitting in ID/EXE.
        if (!rst_n) begin
            pc_write      = 1'b1;
            if_id_write   = 1'b1;
            if_id_flush   = 1'b0;
            id_exe_bubble = 1'b0;
            id_exe_hold   = 1'b0;
            busy          = 1'b0;
        end
    end

    // Saturating performance counters
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (!pc_write && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + 32'd1;
        end
        if (if_id_flush && (flush_count_q != CNT_MAX)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_RUN;
            cnt_q         <= 4'd0;
            stall_count_q <= 32'd0;
            flush_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign PCWrite       = pc_write;
    assign IF_ID_Write   = if_id_write;
    assign IF_ID_Flush   = if_id_flush;
    assign ID_EXE_Bubble = id_exe_bubble;
    assign ID_EXE_Hold   = id_exe_hold;
    assign Busy          = busy;
    assign StallCount    = stall_count_q;
    assign FlushCount    = flush_count_q;

endmodule

// File: tb/tb_exe_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_exe_hazard_unit
//
// Directed scenarios for each hazard class and reset behaviour, followed by a
// randomized run checked against a behavioural model that tracks "cycles of
// EXE occupancy left" and plain integer performance counts.
// Inputs change 1ns after each rising edge; outputs are sampled on the
// falling edge. Control vectors are packed as
// {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EXE_Bubble, ID_EXE_Hold, Busy}.
// -----------------------------------------------------------------------------
module tb_exe_hazard_unit;

    localparam int MUL_N   = 3;
    localparam int DIV_S_N = 6;
    localparam int DIV_D_N = 12;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        ID_EXE_MemRead;
    logic [4:0]  ID_EXE_RtReg;
    logic [4:0]  ID_EXE_fmt;
    logic [5:0]  ID_EXE_Func;
    logic        ID_EXE_double;
    logic [4:0]  IF_ID_Rs;
    logic [4:0]  IF_ID_Rt;
    logic        BranchTaken;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        IF_ID_Flush;
    logic        ID_EXE_Bubble;
    logic        ID_EXE_Hold;
    logic        Busy;
    logic [31:0] StallCount;
    logic [31:0] FlushCount;

    exe_hazard_unit #(
        .MUL_CYCLES  (MUL_N),
        .DIV_S_CYCLES(DIV_S_N),
        .DIV_D_CYCLES(DIV_D_N)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ID_EXE_MemRead(ID_EXE_MemRead),
        .ID_EXE_RtReg  (ID_EXE_RtReg),
        .ID_EXE_fmt    (ID_EXE_fmt),
        .ID_EXE_Func   (ID_EXE_Func),
        .ID_EXE_double (ID_EXE_double),
        .IF_ID_Rs      (IF_ID_Rs),
        .IF_ID_Rt      (IF_ID_Rt),
        .BranchTaken   (BranchTaken),
        .PCWrite       (PCWrite),
        .IF_ID_Write   (IF_ID_Write),
        .IF_ID_Flush   (IF_ID_Flush),
        .ID_EXE_Bubble (ID_EXE_Bubble),
        .ID_EXE_Hold   (ID_EXE_Hold),
        .Busy          (Busy),
        .StallCount    (StallCount),
        .FlushCount    (FlushCount)
    );

    int total = 0;
    int bad   = 0;

    logic [5:0] ctl;
    assign ctl = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EXE_Bubble, ID_EXE_Hold, Busy};

    localparam logic [5:0] CTL_IDLE  = 6'b110000;
    localparam logic [5:0] CTL_LU    = 6'b000100;
    localparam logic [5:0] CTL_BR    = 6'b111100;
    localparam logic [5:0] CTL_HOLD  = 6'b000011;
    localparam logic [5:0] CTL_LAST  = 6'b110001;

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        ID_EXE_MemRead = 1'b0;
        ID_EXE_RtReg   = 5'd0;
        ID_EXE_fmt     = 5'h00;
        ID_EXE_Func    = 6'h00;
        ID_EXE_double  = 1'b0;
        IF_ID_Rs       = 5'd0;
        IF_ID_Rt       = 5'd0;
        BranchTaken    = 1'b0;
    endtask

    task automatic drive_fp(input logic [4:0] fmt, input logic [5:0] func, input logic dbl);
        drive_idle();
        ID_EXE_fmt    = fmt;
        ID_EXE_Func   = func;
        ID_EXE_double = dbl;
        IF_ID_Rs      = 5'd3;
        IF_ID_Rt      = 5'd4;
    endtask

    // Leaves the bench 1ns after a rising edge with reset released.
    task automatic do_reset();
        drive_idle();
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    int          m_left;          // cycles of EXE occupancy remaining, 0 = free
    longint      m_stall;
    longint      m_flush;
    logic [5:0]  m_ctl;
    int          m_left_next;

    function automatic int op_cycles(input logic [5:0] func, input logic dbl);
        if (func == 6'h02) return MUL_N;
        return dbl ? DIV_D_N : DIV_S_N;
    endfunction

    task automatic model_eval();
        logic is_mc, is_lu;
        is_mc = ((ID_EXE_fmt == 5'h10) || (ID_EXE_fmt == 5'h11)) &&
                ((ID_EXE_Func == 6'h02) || (ID_EXE_Func == 6'h03));
        is_lu = ID_EXE_MemRead && (ID_EXE_RtReg != 0) &&
                ((ID_EXE_RtReg == IF_ID_Rs) || (ID_EXE_RtReg == IF_ID_Rt));
        m_left_next = 0;
        if (m_left > 0) begin
            m_ctl       = (m_left > 1) ? CTL_HOLD : CTL_LAST;
            m_left_next = m_left - 1;
        end else if (BranchTaken) begin
            m_ctl = CTL_BR;
        end else if (is_mc) begin
            m_ctl       = CTL_HOLD;
            m_left_next = op_cycles(ID_EXE_Func, ID_EXE_double) - 1;
        end else if (is_lu) begin
            m_ctl = CTL_LU;
        end else begin
            m_ctl = CTL_IDLE;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        #3;
        total++;
        if (ctl !== CTL_IDLE) begin
            bad++;
            $display("FAIL reset_ctl: got %b exp %b", ctl, CTL_IDLE);
        end
        total++;
        if (StallCount !== 32'd0 || FlushCount !== 32'd0) begin
            bad++;
            $display("FAIL reset_counts: got stall=%0d flush=%0d exp 0/0", StallCount, FlushCount);
        end
        do_reset();
        @(negedge clk);
        total++;
        if (ctl !== CTL_IDLE) begin
            bad++;
            $display("FAIL post_reset_ctl: got %b exp %b", ctl, CTL_IDLE);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        do_reset();
        ID_EXE_MemRead = 1'b1;
        ID_EXE_RtReg   = 5'd5;
        IF_ID_Rs       = 5'd2;
        IF_ID_Rt       = 5'd5;
        @(negedge clk);
        total++;
        if (ctl !== CTL_LU) begin
            bad++;
            $display("FAIL load_use_stall: got %b exp %b", ctl, CTL_LU);
        end
        next_cycle();
        ID_EXE_MemRead = 1'b0;   // bubble has cleared the load
        @(negedge clk);
        total++;
        if (ctl !== CTL_IDLE) begin
            bad++;
            $display("FAIL load_use_release: got %b exp %b", ctl, CTL_IDLE);
        end
        total++;
        if (StallCount !== 32'd1 || FlushCount !== 32'd0) begin
            bad++;
            $display("FAIL load_use_counts: got stall=%0d flush=%0d exp 1/0", StallCount, FlushCount);
        end
        next_cycle();
    endtask

    task automatic test_no_hazard();
        do_reset();
        ID_EXE_MemRead = 1'b1;
        ID_EXE_RtReg   = 5'd0;
        IF_ID_Rs       = 5'd0;
        IF_ID_Rt       = 5'd9;
        @(negedge clk);
        total++;
        if (ctl !== CTL_IDLE) begin
            bad++;
            $display("FAIL no_hazard_r0: got %b exp %b", ctl, CTL_IDLE);
        end
        next_cycle();
        ID_EXE_RtReg = 5'd7;
        IF_ID_Rs     = 5'd6;
        IF_ID_Rt     = 5'd8;
        @(negedge clk);
        total++;
        if (ctl !== CTL_IDLE) begin
            bad++;
            $display("FAIL no_hazard_diff: got %b exp %b", ctl, CTL_IDLE);
        end
        next_cycle();
        // FP format with a non-mul/div function is not a multi-cycle op.
        drive_fp(5'h10, 6'h01, 1'b0);
        @(negedge clk);
        total++;
        if (ctl !== CTL_IDLE) begin
            bad++;
            $display("FAIL no_hazard_fpadd: got %b exp %b", ctl, CTL_IDLE);
        end
        next_cycle();
    endtask

    // branch_at: occupancy cycle index at which BranchTaken is pulsed (-1: none)
    task automatic test_multicycle(input string name, input logic [4:0] fmt,
                                   input logic [5:0] func, input logic dbl,
                                   input int n, input int branch_at);
        logic [5:0] exp;
        do_reset();
        drive_fp(fmt, func, dbl);
        for (int i = 0; i < n; i++) begin
            BranchTaken = (i == branch_at);
            exp = (i < n - 1) ? CTL_HOLD : CTL_LAST;
            @(negedge clk);
            total++;
            if (ctl !== exp) begin
                bad++;
                $display("FAIL %s_cycle%0d: got %b exp %b", name, i, ctl, exp);
            end
            next_cycle();
        end
        drive_idle();
        @(negedge clk);
        total++;
        if (ctl !== CTL_IDLE) begin
            bad++;
            $display("FAIL %s_after: got %b exp %b", name, ctl, CTL_IDLE);
        end
        total++;
        if (StallCount !== 32'(n - 1) || FlushCount !== 32'd0) begin
            bad++;
            $display("FAIL %s_counts: got stall=%0d flush=%0d exp %0d/0", name,
                     StallCount, FlushCount, n - 1);
        end
        next_cycle();
    endtask

    task automatic test_branch_over_lu();
        do_reset();
        ID_EXE_MemRead = 1'b1;
        ID_EXE_RtReg   = 5'd5;
        IF_ID_Rs       = 5'd5;
        BranchTaken    = 1'b1;
        @(negedge clk);
        total++;
        if (ctl !== CTL_BR) begin
            bad++;
            $display("FAIL branch_lu_ctl: got %b exp %b", ctl, CTL_BR);
        end
        next_cycle();
        drive_idle();
        @(negedge clk);
        total++;
        if (StallCount !== 32'd0 || FlushCount !== 32'd1) begin
            bad++;
            $display("FAIL branch_lu_counts: got stall=%0d flush=%0d exp 0/1", StallCount, FlushCount);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        drive_fp(5'h11, 6'h03, 1'b1);
        for (int i = 0; i < 3; i++) next_cycle();
        // 4th occupancy cycle: assert reset away from the edge, op still present.
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (ctl !== CTL_IDLE) begin
            bad++;
            $display("FAIL midrst_ctl: got %b exp %b", ctl, CTL_IDLE);
        end
        total++;
        if (StallCount !== 32'd0 || FlushCount !== 32'd0) begin
            bad++;
            $display("FAIL midrst_counts: got stall=%0d flush=%0d exp 0/0", StallCount, FlushCount);
        end
        drive_idle();
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (ctl !== CTL_IDLE) begin
            bad++;
            $display("FAIL midrst_release: got %b exp %b", ctl, CTL_IDLE);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (StallCount !== 32'd0) begin
            bad++;
            $display("FAIL midrst_nostall: got stall=%0d exp 0", StallCount);
        end
        next_cycle();
    endtask

    task automatic test_random(input int cycles);
        int pick;
        do_reset();
        m_left  = 0;
        m_stall = 0;
        m_flush = 0;
        for (int c = 0; c < cycles; c++) begin
            // Stimulus: a held op stays in ID/EXE while it occupies EXE.
            if (m_left == 0) begin
                pick = $urandom_range(0, 7);
                if (pick == 0) begin
                    ID_EXE_fmt    = ($urandom_range(0, 1) == 1) ? 5'h11 : 5'h10;
                    ID_EXE_Func   = ($urandom_range(0, 1) == 1) ? 6'h03 : 6'h02;
                    ID_EXE_double = 1'($urandom_range(0, 1));
                end else begin
                    ID_EXE_fmt    = ($urandom_range(0, 3) == 0) ? 5'h10 : 5'($urandom_range(0, 31));
                    ID_EXE_Func   = 6'($urandom_range(0, 7));
                    ID_EXE_double = 1'($urandom_range(0, 1));
                end
                ID_EXE_MemRead = ($urandom_range(0, 2) == 0);
                ID_EXE_RtReg   = 5'($urandom_range(0, 7));
            end
            IF_ID_Rs    = 5'($urandom_range(0, 7));
            IF_ID_Rt    = 5'($urandom_range(0, 7));
            BranchTaken = ($urandom_range(0, 5) == 0);

            @(negedge clk);
            total++;
            if (StallCount !== 32'(m_stall) || FlushCount !== 32'(m_flush)) begin
                bad++;
                $display("FAIL rand_counts c%0d: got stall=%0d flush=%0d exp %0d/%0d",
                         c, StallCount, FlushCount, m_stall, m_flush);
            end
            model_eval();
            total++;
            if (ctl !== m_ctl) begin
                bad++;
                $display("FAIL rand_ctl c%0d: got %b exp %b (left=%0d)", c, ctl, m_ctl, m_left);
            end
            @(posedge clk);
            if (!m_ctl[5]) m_stall++;
            if (m_ctl[3])  m_flush++;
            m_left = m_left_next;
            #1;
        end
    endtask

    // ---------------- main sequence + report ----------------
    initial begin
        drive_idle();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_multicycle("divd", 5'h11, 6'h03, 1'b1, DIV_D_N, -1);
        test_multicycle("muls", 5'h10, 6'h02, 1'b0, MUL_N, -1);
        test_multicycle("muld", 5'h11, 6'h02, 1'b1, MUL_N, -1);
        test_multicycle("divs_br", 5'h10, 6'h03, 1'b0, DIV_S_N, 2);
        test_branch_over_lu();
        test_reset_mid_op();
        test_random(3000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound in case a task never returns.
    initial begin
        #500000;
        $display("FAIL timeout: got no completion exp completion by 500000ns");
        $fatal(1);
    end

endmodule
